// File: rtl/isp_dgain_bayer.sv
// Bayer-domain digital gain: black-level subtract, per-channel gain with rounding
// and clipping, frame-synchronous shadowed configuration and per-frame clip statistics.
module isp_dgain_bayer #(
  parameter int DW   = 8,
  parameter int GW   = 8,
  parameter int FB   = 4,
  parameter int CNTW = 24
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            dgain_en,
  input  logic [1:0]      bayer_pat,
  input  logic [GW-1:0]   gain_r,
  input  logic [GW-1:0]   gain_gr,
  input  logic [GW-1:0]   gain_gb,
  input  logic [GW-1:0]   gain_b,
  input  logic [DW-1:0]   dgain_offset,
  input  logic [DW-1:0]   in_raw,
  input  logic            in_href,
  input  logic            in_vsync,
  output logic [DW-1:0]   out_raw,
  output logic            out_href,
  output logic            out_vsync,
  output logic [CNTW-1:0] sat_cnt,
  output logic            sat_cnt_vld
);

  localparam int PW = DW + GW;
  localparam logic [GW-1:0] UNITY = GW'(1) << FB;
  localparam logic [PW:0]   HALF  = ((PW+1)'(1) << FB) >> 1;
  localparam logic [PW:0]   MAXV  = {{(GW+1){1'b0}}, {DW{1'b1}}};

  function automatic logic [PW:0] rnd(input logic [PW-1:0] p);
    return ({1'b0, p} + HALF) >> FB;
  endfunction

  function automatic logic [DW-1:0] sat(input logic [PW:0] v);
    return (v > MAXV) ? {DW{1'b1}} : v[DW-1:0];
  endfunction

  logic            vs_q, vs_d;
  logic            c_q, c_d, r_q, r_d;
  logic            en_sh_q, en_sh_d;
  logic [1:0]      pat_sh_q, pat_sh_d;
  logic [GW-1:0]   g_r_sh_q, g_r_sh_d, g_gr_sh_q, g_gr_sh_d;
  logic [GW-1:0]   g_gb_sh_q, g_gb_sh_d, g_b_sh_q, g_b_sh_d;
  logic [DW-1:0]   off_sh_q, off_sh_d;

  logic [DW-1:0]   diff_p1_q, diff_p1_d;
  logic [GW-1:0]   gain_p1_q, gain_p1_d;
  logic            en_p1_q, en_p1_d, href_p1_q, href_p1_d, vsync_p1_q, vsync_p1_d;
  logic [PW-1:0]   prod_p2_q, prod_p2_d;
  logic            en_p2_q, en_p2_d, href_p2_q, href_p2_d, vsync_p2_q, vsync_p2_d;
  logic [DW-1:0]   raw_p3_q, raw_p3_d;
  logic            href_p3_q, href_p3_d, vsync_p3_q, vsync_p3_d;

  logic [CNTW-1:0] run_cnt_q, run_cnt_d, sat_cnt_q, sat_cnt_d;
  logic            sat_vld_q, sat_vld_d;

  logic            vs_rise;
  logic [GW-1:0]   gsel;
  logic [PW:0]     q_s3;
  logic            clip_s3;

  assign vs_rise = in_vsync & ~vs_q;

  // Shadow capture and Bayer position tracking
  always_comb begin
    vs_d     = in_vsync;
    en_sh_d  = en_sh_q;
    pat_sh_d = pat_sh_q;
    g_r_sh_d = g_r_sh_q;
    g_gr_sh_d = g_gr_sh_q;
    g_gb_sh_d = g_gb_sh_q;
    g_b_sh_d = g_b_sh_q;
    off_sh_d = off_sh_q;
    if (vs_rise) begin
      en_sh_d   = dgain_en;
      pat_sh_d  = bayer_pat;
      g_r_sh_d  = gain_r;
      g_gr_sh_d = gain_gr;
      g_gb_sh_d = gain_gb;
      g_b_sh_d  = gain_b;
      off_sh_d  = dgain_offset;
    end
    c_d = in_href ? ~c_q : 1'b0;
    r_d = r_q;
    if (vs_rise)
      r_d = 1'b0;
    else if (href_p1_q && !in_href)
      r_d = ~r_q;
  end

  always_comb begin
    gsel = g_r_sh_q;
    case ({r_q ^ pat_sh_q[1], c_q ^ pat_sh_q[0]})
      2'b00:   gsel = g_r_sh_q;
      2'b01:   gsel = g_gr_sh_q;
      2'b10:   gsel = g_gb_sh_q;
      default: gsel = g_b_sh_q;
    endcase
  end

  // S1: black-level subtract, gain select (unity in bypass)
  always_comb begin
    diff_p1_d  = en_sh_q ? ((in_raw > off_sh_q) ? in_raw - off_sh_q : '0) : in_raw;
    gain_p1_d  = en_sh_q ? gsel : UNITY;
    en_p1_d    = en_sh_q;
    href_p1_d  = in_href;
    vsync_p1_d = in_vsync;
  end

  // S2: multiply
  always_comb begin
    prod_p2_d  = PW'(diff_p1_q) * PW'(gain_p1_q);
    en_p2_d    = en_p1_q;
    href_p2_d  = href_p1_q;
    vsync_p2_d = vsync_p1_q;
  end

  // S3: round, clip and clip statistics
  always_comb begin
    q_s3       = rnd(prod_p2_q);
    clip_s3    = en_p2_q && (q_s3 > MAXV);
    raw_p3_d   = sat(q_s3);
    href_p3_d  = href_p2_q;
    vsync_p3_d = vsync_p2_q;
    run_cnt_d  = run_cnt_q;
    if (vs_rise)
      run_cnt_d = '0;
    else if (href_p2_q && clip_s3 && run_cnt_q != {CNTW{1'b1}})
      run_cnt_d = run_cnt_q + 1'b1;
    sat_cnt_d = vs_rise ? run_cnt_q : sat_cnt_q;
    sat_vld_d = vs_rise;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q       <= 1'b0;
      c_q        <= 1'b0;
      r_q        <= 1'b0;
      en_sh_q    <= 1'b0;
      pat_sh_q   <= 2'd0;
      g_r_sh_q   <= UNITY;
      g_gr_sh_q  <= UNITY;
      g_gb_sh_q  <= UNITY;
      g_b_sh_q   <= UNITY;
      off_sh_q   <= '0;
      diff_p1_q  <= '0;
      gain_p1_q  <= '0;
      en_p1_q    <= 1'b0;
      href_p1_q  <= 1'b0;
      vsync_p1_q <= 1'b0;
      prod_p2_q  <= '0;
      en_p2_q    <= 1'b0;
      href_p2_q  <= 1'b0;
      vsync_p2_q <= 1'b0;
      raw_p3_q   <= '0;
      href_p3_q  <= 1'b0;
      vsync_p3_q <= 1'b0;
      run_cnt_q  <= '0;
      sat_cnt_q  <= '0;
      sat_vld_q  <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      c_q        <= c_d;
      r_q        <= r_d;
      en_sh_q    <= en_sh_d;
      pat_sh_q   <= pat_sh_d;
      g_r_sh_q   <= g_r_sh_d;
      g_gr_sh_q  <= g_gr_sh_d;
      g_gb_sh_q  <= g_gb_sh_d;
      g_b_sh_q   <= g_b_sh_d;
      off_sh_q   <= off_sh_d;
      diff_p1_q  <= diff_p1_d;
      gain_p1_q  <= gain_p1_d;
      en_p1_q    <= en_p1_d;
      href_p1_q  <= href_p1_d;
      vsync_p1_q <= vsync_p1_d;
      prod_p2_q  <= prod_p2_d;
      en_p2_q    <= en_p2_d;
      href_p2_q  <= href_p2_d;
      vsync_p2_q <= vsync_p2_d;
      raw_p3_q   <= raw_p3_d;
      href_p3_q  <= href_p3_d;
      vsync_p3_q <= vsync_p3_d;
      run_cnt_q  <= run_cnt_d;
      sat_cnt_q  <= sat_cnt_d;
      sat_vld_q  <= sat_vld_d;
    end
  end

  assign out_raw     = raw_p3_q;
  assign out_href    = href_p3_q;
  assign out_vsync   = vsync_p3_q;
  assign sat_cnt     = sat_cnt_q;
  assign sat_cnt_vld = sat_vld_q;

endmodule

// File: tb/tb_isp_dgain_bayer.sv
// Directed-vector bench for isp_dgain_bayer with default parameters (DW=8, GW=8, FB=4).
module tb_isp_dgain_bayer;

  logic        pclk, rst, dgain_en, in_href, in_vsync;
  logic [1:0]  bayer_pat;
  logic [7:0]  gain_r, gain_gr, gain_gb, gain_b, dgain_offset, in_raw;
  logic [7:0]  out_raw;
  logic        out_href, out_vsync, sat_cnt_vld;
  logic [23:0] sat_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  lg_raw[$];
  logic        lg_href[$];
  logic        lg_vs[$];
  logic [23:0] lg_cnt[$];
  logic        lg_vld[$];

  isp_dgain_bayer dut (
    .pclk(pclk), .rst(rst), .dgain_en(dgain_en), .bayer_pat(bayer_pat),
    .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
    .dgain_offset(dgain_offset), .in_raw(in_raw), .in_href(in_href),
    .in_vsync(in_vsync), .out_raw(out_raw), .out_href(out_href),
    .out_vsync(out_vsync), .sat_cnt(sat_cnt), .sat_cnt_vld(sat_cnt_vld)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // One pixel cycle; the log entry at index i is the output state after that cycle's edge.
  task automatic px(input logic [7:0] raw, input logic href, input logic vs);
    in_raw = raw; in_href = href; in_vsync = vs;
    @(posedge pclk); #1;
    lg_raw.push_back(out_raw);
    lg_href.push_back(out_href);
    lg_vs.push_back(out_vsync);
    lg_cnt.push_back(sat_cnt);
    lg_vld.push_back(sat_cnt_vld);
  endtask

  task automatic set_cfg(input logic en, input logic [1:0] pat, input logic [7:0] r,
                         input logic [7:0] gr, input logic [7:0] gb, input logic [7:0] b,
                         input logic [7:0] off);
    dgain_en = en; bayer_pat = pat; gain_r = r; gain_gr = gr; gain_gb = gb;
    gain_b = b; dgain_offset = off;
  endtask

  task automatic frame_start(output int iv);
    iv = lg_raw.size();
    px(8'd0, 1'b0, 1'b1);
    px(8'd0, 1'b0, 1'b0);
    px(8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_cfg(1'b0, 2'd0, 8'd16, 8'd16, 8'd16, 8'd16, 8'd0);
    in_raw = 8'd0; in_href = 1'b0; in_vsync = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++; if (out_raw !== 8'd0) begin errors++; $display("FAIL reset_raw: got %0d expected 0", out_raw); end
    checks++; if (out_href !== 1'b0) begin errors++; $display("FAIL reset_href: got %0b expected 0", out_href); end
    checks++; if (out_vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %0b expected 0", out_vsync); end
    checks++; if (sat_cnt !== 24'd0) begin errors++; $display("FAIL reset_sat_cnt: got %0d expected 0", sat_cnt); end
    checks++; if (sat_cnt_vld !== 1'b0) begin errors++; $display("FAIL reset_sat_vld: got %0b expected 0", sat_cnt_vld); end
    rst = 1'b0;
    px(8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_unity_ramp;
    int iv;
    int base[4];
    set_cfg(1'b1, 2'd0, 8'd16, 8'd16, 8'd16, 8'd16, 8'd0);
    frame_start(iv);
    for (int l = 0; l < 4; l++) begin
      base[l] = lg_raw.size();
      for (int k = 0; k < 8; k++) px(8'((l * 8 + k) * 8), 1'b1, 1'b0);
      px(8'd0, 1'b0, 1'b0);
      px(8'd0, 1'b0, 1'b0);
    end
    px(8'd0, 1'b0, 1'b0);
    checks++; if (lg_vs[iv+1] !== 1'b0) begin errors++; $display("FAIL unity_vsync_early: got %0b expected 0", lg_vs[iv+1]); end
    checks++; if (lg_vs[iv+2] !== 1'b1) begin errors++; $display("FAIL unity_vsync_lat3: got %0b expected 1", lg_vs[iv+2]); end
    checks++; if (lg_vs[iv+3] !== 1'b0) begin errors++; $display("FAIL unity_vsync_end: got %0b expected 0", lg_vs[iv+3]); end
    checks++; if (lg_vld[iv] !== 1'b1) begin errors++; $display("FAIL first_vsync_vld: got %0b expected 1", lg_vld[iv]); end
    checks++; if (lg_cnt[iv] !== 24'd0) begin errors++; $display("FAIL first_vsync_cnt: got %0d expected 0", lg_cnt[iv]); end
    checks++; if (lg_vld[iv+1] !== 1'b0) begin errors++; $display("FAIL first_vsync_pulse: got %0b expected 0", lg_vld[iv+1]); end
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (lg_raw[base[l]+k+2] !== 8'((l * 8 + k) * 8)) begin
          errors++;
          $display("FAIL unity_raw l%0d k%0d: got %0d expected %0d", l, k, lg_raw[base[l]+k+2], (l * 8 + k) * 8);
        end
        checks++;
        if (lg_href[base[l]+k+2] !== 1'b1) begin
          errors++;
          $display("FAIL unity_href l%0d k%0d: got %0b expected 1", l, k, lg_href[base[l]+k+2]);
        end
      end
      checks++;
      if (lg_href[base[l]+10] !== 1'b0) begin
        errors++;
        $display("FAIL unity_href_low l%0d: got %0b expected 0", l, lg_href[base[l]+10]);
      end
    end
  endtask

  task automatic test_channel_gains;
    int iv, b0, b1;
    set_cfg(1'b1, 2'd0, 8'd32, 8'd16, 8'd16, 8'd24, 8'd16);
    frame_start(iv);
    b0 = lg_raw.size();
    px(8'd100, 1'b1, 1'b0); px(8'd100, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0);   px(8'd0, 1'b0, 1'b0);
    b1 = lg_raw.size();
    px(8'd17, 1'b1, 1'b0);  px(8'd17, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0);   px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0);
    checks++; if (lg_raw[b0+2] !== 8'd168) begin errors++; $display("FAIL gain_r: got %0d expected 168", lg_raw[b0+2]); end
    checks++; if (lg_raw[b0+3] !== 8'd84) begin errors++; $display("FAIL gain_gr: got %0d expected 84", lg_raw[b0+3]); end
    checks++; if (lg_raw[b1+2] !== 8'd1) begin errors++; $display("FAIL gain_gb: got %0d expected 1", lg_raw[b1+2]); end
    checks++; if (lg_raw[b1+3] !== 8'd2) begin errors++; $display("FAIL gain_b_round: got %0d expected 2", lg_raw[b1+3]); end
  endtask

  task automatic test_clip_stats;
    int iv, b;
    set_cfg(1'b1, 2'd0, 8'd32, 8'd16, 8'd16, 8'd16, 8'd16);
    frame_start(iv);
    b = lg_raw.size();
    for (int k = 0; k < 20; k++) px(8'd200, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0);
    frame_start(iv);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (lg_raw[b+k+2] !== ((k % 2 == 0) ? 8'd255 : 8'd184)) begin
        errors++;
        $display("FAIL clip_raw k%0d: got %0d expected %0d", k, lg_raw[b+k+2], (k % 2 == 0) ? 255 : 184);
      end
    end
    checks++; if (lg_vld[iv] !== 1'b1) begin errors++; $display("FAIL clip_vld: got %0b expected 1", lg_vld[iv]); end
    checks++; if (lg_cnt[iv] !== 24'd10) begin errors++; $display("FAIL clip_cnt: got %0d expected 10", lg_cnt[iv]); end
    checks++; if (lg_vld[iv+1] !== 1'b0) begin errors++; $display("FAIL clip_vld_pulse: got %0b expected 0", lg_vld[iv+1]); end
    checks++; if (lg_cnt[iv+1] !== 24'd10) begin errors++; $display("FAIL clip_cnt_hold: got %0d expected 10", lg_cnt[iv+1]); end
  endtask

  task automatic test_shadowing;
    int iv, b;
    set_cfg(1'b1, 2'd0, 8'd16, 8'd16, 8'd16, 8'd16, 8'd0);
    frame_start(iv);
    gain_r = 8'd32;
    dgain_offset = 8'd50;
    px(8'd0, 1'b0, 1'b0);
    b = lg_raw.size();
    px(8'd100, 1'b1, 1'b0); px(8'd100, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0);   px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0);
    checks++; if (lg_raw[b+2] !== 8'd100) begin errors++; $display("FAIL shadow_hold_r: got %0d expected 100", lg_raw[b+2]); end
    checks++; if (lg_raw[b+3] !== 8'd100) begin errors++; $display("FAIL shadow_hold_gr: got %0d expected 100", lg_raw[b+3]); end
    dgain_offset = 8'd0;
    frame_start(iv);
    b = lg_raw.size();
    px(8'd100, 1'b1, 1'b0); px(8'd100, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0);   px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0);
    checks++; if (lg_raw[b+2] !== 8'd200) begin errors++; $display("FAIL shadow_new_r: got %0d expected 200", lg_raw[b+2]); end
    checks++; if (lg_raw[b+3] !== 8'd100) begin errors++; $display("FAIL shadow_new_gr: got %0d expected 100", lg_raw[b+3]); end
  endtask

  // Three-pixel lines also cover the odd-width column restart.
  task automatic test_pattern_sweep;
    int iv, b;
    logic [7:0] exp_v;
    logic [1:0] pat;
    for (int p = 0; p < 4; p++) begin
      pat = 2'(p);
      set_cfg(1'b1, pat, 8'd16, 8'd32, 8'd48, 8'd64, 8'd0);
      frame_start(iv);
      for (int row = 0; row < 2; row++) begin
        b = lg_raw.size();
        px(8'd10, 1'b1, 1'b0); px(8'd10, 1'b1, 1'b0); px(8'd10, 1'b1, 1'b0);
        px(8'd0, 1'b0, 1'b0);  px(8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
          exp_v = 8'(10 * (1 + 2 * (row ^ int'(pat[1])) + ((k & 1) ^ int'(pat[0]))));
          checks++;
          if (lg_raw[b+k+2] !== exp_v) begin
            errors++;
            $display("FAIL pattern p%0d row%0d col%0d: got %0d expected %0d", p, row, k, lg_raw[b+k+2], exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_line;
    int iv, b;
    set_cfg(1'b1, 2'd0, 8'd32, 8'd32, 8'd32, 8'd32, 8'd0);
    for (int k = 0; k < 5; k++) px(8'd50, 1'b1, 1'b0);
    checks++; if (out_href !== 1'b1) begin errors++; $display("FAIL midrst_pre_href: got %0b expected 1", out_href); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_raw !== 8'd0) begin errors++; $display("FAIL midrst_raw: got %0d expected 0", out_raw); end
    checks++; if (out_href !== 1'b0) begin errors++; $display("FAIL midrst_href: got %0b expected 0", out_href); end
    checks++; if (out_vsync !== 1'b0) begin errors++; $display("FAIL midrst_vsync: got %0b expected 0", out_vsync); end
    checks++; if (sat_cnt !== 24'd0) begin errors++; $display("FAIL midrst_sat_cnt: got %0d expected 0", sat_cnt); end
    checks++; if (sat_cnt_vld !== 1'b0) begin errors++; $display("FAIL midrst_sat_vld: got %0b expected 0", sat_cnt_vld); end
    #2 rst = 1'b0;
    px(8'd0, 1'b0, 1'b0);
    b = lg_raw.size();
    for (int k = 0; k < 4; k++) px(8'd50, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (lg_raw[b+k+2] !== 8'd50) begin
        errors++;
        $display("FAIL midrst_bypass k%0d: got %0d expected 50", k, lg_raw[b+k+2]);
      end
    end
    frame_start(iv);
    checks++; if (lg_cnt[iv] !== 24'd0) begin errors++; $display("FAIL midrst_first_cnt: got %0d expected 0", lg_cnt[iv]); end
    checks++; if (lg_vld[iv] !== 1'b1) begin errors++; $display("FAIL midrst_first_vld: got %0b expected 1", lg_vld[iv]); end
    b = lg_raw.size();
    px(8'd50, 1'b1, 1'b0); px(8'd50, 1'b1, 1'b0);
    px(8'd0, 1'b0, 1'b0);  px(8'd0, 1'b0, 1'b0); px(8'd0, 1'b0, 1'b0);
    checks++; if (lg_raw[b+2] !== 8'd100) begin errors++; $display("FAIL midrst_gain_r: got %0d expected 100", lg_raw[b+2]); end
    checks++; if (lg_raw[b+3] !== 8'd100) begin errors++; $display("FAIL midrst_gain_gr: got %0d expected 100", lg_raw[b+3]); end
    checks++; if (lg_href[b+3] !== 1'b1) begin errors++; $display("FAIL midrst_href_out: got %0b expected 1", lg_href[b+3]); end
  endtask

  initial begin
    test_reset;
    test_unity_ramp;
    test_channel_gains;
    test_clip_stats;
    test_shadowing;
    test_pattern_sweep;
    test_reset_mid_line;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isp_dgain_bayer.md
# isp_dgain_bayer

Parametrised Bayer-domain digital gain stage for the ISP raw pipeline, placed between the sensor raw input and the demosaic block. It applies black-level subtraction and a per-colour-channel gain (R, Gr, Gb, B) with rounding and clipping. The Bayer phase is selectable. Configuration is shadowed and takes effect only at frame boundaries. A per-frame count of clipped pixels is reported for auto-exposure. Compared with the single-gain 8-bit predecessor, this block adds generalised widths, four independent channel gains, pattern selection, frame-synchronous register update and saturation statistics.

## Interface
Parameters:
- DW, 8, raw pixel width (in and out)
- GW, 8, gain width, unsigned fixed point
- FB, 4, fractional bits of gain (unity = 1<<FB)
- CNTW, 24, saturation counter width

Ports:
- pclk  in  1  pixel clock, the only clock
- rst  in  1  reset, asynchronous, active-high
- dgain_en  in  1  1 = apply offset/gain; 0 = bypass (latency preserved)
- bayer_pat  in  2  0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
- gain_r, gain_gr, gain_gb, gain_b  in  GW each  channel gains
- dgain_offset  in  DW  black level subtracted before gain
- in_raw  in  DW  raw pixel
- in_href  in  1  line valid, active-high
- in_vsync  in  1  frame sync, active-high
- out_raw  out  DW  processed pixel
- out_href  out  1  in_href delayed 3
- out_vsync  out  1  in_vsync delayed 3
- sat_cnt  out  CNTW  clipped-pixel count of last completed frame
- sat_cnt_vld  out  1  one-cycle pulse when sat_cnt updates

## Operation
- Shadow registers: dgain_en, bayer_pat, the four gains and dgain_offset are captured on the in_vsync rising edge. Edge detection uses a registered copy vs_q: capture occurs in the cycle with in_vsync=1 and vs_q=0. Between edges, input changes have no effect.
- Position tracking:
  - col parity c toggles every cycle in_href=1 and clears when in_href=0.
  - row parity r toggles on each in_href falling edge and clears on the in_vsync rising edge.
- Channel select: idx_r = r ^ bayer_pat[1], idx_c = c ^ bayer_pat[0]. The pair (idx_r, idx_c) maps as follows: (0,0) R, (0,1) Gr, (1,0) Gb, (1,1) B.
- Pipeline:
  - S1 registers d = in_raw > off ? in_raw - off : 0 (DW bits) and the selected gain.
  - S2 registers p = d * g (DW+GW bits).
  - S3 computes q = (p + (1<<(FB-1))) >> FB, with no rounding add when FB=0. If q > 2^DW-1, then out_raw = 2^DW-1 and clip=1; otherwise out_raw = q.
- Bypass (shadow dgain_en=0): out_raw = in_raw delayed 3 cycles, and clip is forced to 0.
- Statistics:
  - The running counter increments when S3 valid (href delayed 2 = 1) and clip=1. It saturates at all-ones.
  - On the in_vsync rising edge, sat_cnt takes the running count in the next cycle, sat_cnt_vld pulses high for that cycle, and the running count clears to 0 (an increment in the same cycle is lost).
  - The first vsync after reset reports 0.
- Pixels outside href still flow through the pipe. out_raw is don't-care when out_href=0, but is deterministic (computed from in_raw).

## Timing
- Latency: in_raw/in_href/in_vsync at cycle N appear at out_* at N+3, in both process and bypass mode. Throughput is 1 pixel/cycle with no stalls.
- Reset (async assert, sync deassert by system):
  - out_raw=0, out_href=0, out_vsync=0, sat_cnt=0, sat_cnt_vld=0.
  - Pipeline stages, c, r, vs_q and the running count are 0.
  - Shadows reset to: all gains = 1<<FB, offset=0, dgain_en=0, bayer_pat=0.
- Reset mid-frame: outputs drop to 0 immediately. After release, the output stays in bypass with reset shadows until the next vsync rising edge.
- A vsync rising edge coinciding with in_href=1 is a protocol violation. Shadows still update, and r clears.
- Odd line widths: c clears on every href low, so each line starts on column phase 0.

## Test plan
- Unity gain, offset 0, en=1, ramp 0..255 over an 8-pixel-wide, 4-line frame -> out_raw equals input delayed exactly 3 cycles; out_href/out_vsync match.
- RGGB, offset=16, gain_r=32, gain_gr=gain_gb=16, gain_b=24, row 0 = {100,100} -> outputs {168,84}. Row 1 = {17,17} -> outputs {1, 2} (Gb: 1*16=16 -> 1; B: (1*24+8)>>4 = 2).
- Clip: gain_r=32, offset=16, in=200 on 10 R pixels per frame -> out=255 for each. The next vsync gives sat_cnt=10 and a one-cycle sat_cnt_vld.
- Shadowing: change gain_r from 16 to 32 mid-frame -> the current frame is unaffected (in=100 -> 100). The next frame gives 200.
- Pattern sweep bayer_pat=0..3 with distinct gains 16/32/48/64 and constant in=10 -> the 2x2 output tile is a permuted {10,20,30,40} per the mapping.
- Assert rst mid-line -> all outputs 0 asynchronously. After release with en input=1 and gain=32, output passes through unchanged until the next vsync, then doubles.
